// File: rtl/neuron_bit_serializer.sv
// rtl/neuron_bit_serializer.sv - double-buffered bit-plane serializer, MSB first
// Takes a Tw x Ti brick of N-bit neurons and emits one bit-plane per cycle for p cycles.
module neuron_bit_serializer #(
    parameter int N  = 16,
    parameter int Ti = 16,
    parameter int Tw = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        i_precision,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [N*Ti*Tw-1:0] i_neurons,
    input  logic              i_stall,
    output logic              o_valid,
    output logic              o_first_cycle,
    output logic              o_last_cycle,
    output logic [Ti*Tw-1:0]  o_neurons
);
    localparam int L = Ti * Tw;
    localparam int W = N * L;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t       state;
    logic [W-1:0] shadow;
    logic [W-1:0] active;
    logic [4:0]   shadow_p;
    logic [4:0]   cnt;
    logic         shadow_full;
    logic         shadow_full_d;
    logic         accept;
    logic         take;
    logic [4:0]   p_in;

    // Move the p-bit sign bit of every word up to bit N-1; bits above p fall off.
    function automatic logic [W-1:0] align(input logic [W-1:0] d, input logic [4:0] p);
        logic [W-1:0] r;
        logic [4:0]   sh;
        sh = 5'(N) - p;
        for (int k = 0; k < L; k++) begin
            r[N*k +: N] = d[N*k +: N] << sh;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] shift1(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < L; k++) begin
            r[N*k +: N] = {d[N*k +: N-1], 1'b0};
        end
        return r;
    endfunction

    assign p_in   = (i_precision == 5'd0 || int'(i_precision) > N) ? 5'(N) : i_precision;
    assign accept = i_valid & o_ready;
    // Shadow drains either into an idle engine or on the final plane of the current brick.
    assign take   = shadow_full & ((state == IDLE) | (cnt == 5'd0 & ~i_stall));

    always_comb begin
        shadow_full_d = shadow_full;
        if (accept) begin
            shadow_full_d = 1'b1;
        end else if (take) begin
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shadow        <= '0;
            active        <= '0;
            shadow_p      <= '0;
            cnt           <= '0;
            shadow_full   <= 1'b0;
            o_ready       <= 1'b0;
            o_valid       <= 1'b0;
            o_first_cycle <= 1'b0;
            o_last_cycle  <= 1'b0;
        end else begin
            shadow_full <= shadow_full_d;
            o_ready     <= ~shadow_full_d;
            if (accept) begin
                shadow   <= i_neurons;
                shadow_p <= p_in;
            end
            if (take) begin
                state         <= SHIFT;
                active        <= align(shadow, shadow_p);
                cnt           <= shadow_p - 5'd1;
                o_valid       <= 1'b1;
                o_first_cycle <= 1'b1;
                o_last_cycle  <= (shadow_p == 5'd1);
            end else if (state == SHIFT && !i_stall) begin
                if (cnt == 5'd0) begin
                    state         <= IDLE;
                    active        <= '0;
                    o_valid       <= 1'b0;
                    o_first_cycle <= 1'b0;
                    o_last_cycle  <= 1'b0;
                end else begin
                    active        <= shift1(active);
                    cnt           <= cnt - 5'd1;
                    o_first_cycle <= 1'b0;
                    o_last_cycle  <= (cnt == 5'd1);
                end
            end
        end
    end

    always_comb begin
        o_neurons = '0;
        for (int k = 0; k < L; k++) begin
            o_neurons[k] = active[N*k + N - 1];
        end
    end
endmodule
